// File: rtl/zero_stuff_interpolator.sv
// Zero-stuffing AXI-Stream upsampler: each accepted symbol is followed by L-1 stuffed beats, with L latched per frame.
// Define ZERO_STUFF_SAMPLE_HOLD_EN to repeat the held sample on stuffed beats (zero-order hold) instead of emitting 0.
module zero_stuff_interpolator #(
  parameter  int DATA_WIDTH = 16,
  parameter  int MAX_FACTOR = 16,
  localparam int FW         = $clog2(MAX_FACTOR + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [FW-1:0]         interp_factor,
  output logic                  data_in_tready,
  input  logic [DATA_WIDTH-1:0] data_in_tdata,
  input  logic                  data_in_tlast,
  input  logic                  data_in_tvalid,
  input  logic                  data_out_tready,
  output logic [DATA_WIDTH-1:0] data_out_tdata,
  output logic                  data_out_tlast,
  output logic                  data_out_tvalid,
  output logic                  busy
);

  typedef enum logic {EMPTY, EMIT} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [FW-1:0]         ph_q, ph_d;
  logic [FW-1:0]         f_q, f_d;
  logic                  frame_active_q, frame_active_d;
  logic                  last_pending_q, last_pending_d;

  logic          out_valid, final_beat, out_hs, in_hs, frame_end, frame_start;
  logic [FW-1:0] f_req;

  always_comb begin
    out_valid  = (state_q == EMIT);
    final_beat = (ph_q == f_q - FW'(1));
    out_hs     = out_valid & data_out_tready;
    frame_end  = out_hs & final_beat & last_pending_q;

    data_in_tready = !out_valid | (data_out_tready & final_beat);
    in_hs          = data_in_tvalid & data_in_tready;
    // A new frame may start in the same cycle the previous frame's tlast beat leaves.
    frame_start    = in_hs & (!frame_active_q | frame_end);

    if (interp_factor == '0)
      f_req = FW'(1);
    else if (interp_factor > FW'(MAX_FACTOR))
      f_req = FW'(MAX_FACTOR);
    else
      f_req = interp_factor;

    data_out_tdata  = data_q;
    data_out_tvalid = out_valid;
    data_out_tlast  = last_pending_q & final_beat & out_valid;
    busy            = out_valid | frame_active_q;

    state_d        = state_q;
    data_d         = data_q;
    ph_d           = ph_q;
    f_d            = f_q;
    frame_active_d = frame_active_q;
    last_pending_d = last_pending_q;

    if (frame_end)
      frame_active_d = 1'b0;
    if (frame_start) begin
      f_d            = f_req;
      frame_active_d = 1'b1;
    end

    if (in_hs) begin
      state_d        = EMIT;
      data_d         = data_in_tdata;
      ph_d           = '0;
      last_pending_d = data_in_tlast;
    end else if (out_hs) begin
      if (final_beat) begin
        state_d = EMPTY;
      end else begin
        ph_d = ph_q + FW'(1);
`ifdef ZERO_STUFF_SAMPLE_HOLD_EN
        data_d = data_q;
`else
        data_d = '0;
`endif
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= EMPTY;
      data_q         <= '0;
      ph_q           <= '0;
      f_q            <= FW'(1);
      frame_active_q <= 1'b0;
      last_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      data_q         <= data_d;
      ph_q           <= ph_d;
      f_q            <= f_d;
      frame_active_q <= frame_active_d;
      last_pending_q <= last_pending_d;
    end
  end

endmodule

// File: tb/tb_zero_stuff_interpolator.sv
// Directed bench for zero_stuff_interpolator: expected streams are hand-built symbol by symbol.
// Honours ZERO_STUFF_SAMPLE_HOLD_EN for the value carried on stuffed beats.
module tb_zero_stuff_interpolator;
  localparam int DW = 16;
  localparam int MF = 16;
  localparam int FW = $clog2(MF + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic [FW-1:0] interp_factor;
  logic          data_in_tready;
  logic [DW-1:0] data_in_tdata;
  logic          data_in_tlast;
  logic          data_in_tvalid;
  logic          data_out_tready;
  logic [DW-1:0] data_out_tdata;
  logic          data_out_tlast;
  logic          data_out_tvalid;
  logic          busy;

  zero_stuff_interpolator #(.DATA_WIDTH(DW), .MAX_FACTOR(MF)) dut (
    .clock(clock), .reset(reset), .interp_factor(interp_factor),
    .data_in_tready(data_in_tready), .data_in_tdata(data_in_tdata),
    .data_in_tlast(data_in_tlast), .data_in_tvalid(data_in_tvalid),
    .data_out_tready(data_out_tready), .data_out_tdata(data_out_tdata),
    .data_out_tlast(data_out_tlast), .data_out_tvalid(data_out_tvalid),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] in_v[$];
  logic          in_l[$];
  logic [DW-1:0] ev[$];
  logic          el[$];
  logic [DW-1:0] ov[$];
  logic          ol[$];
  int            oc[$];
  int            ic[$];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [DW-1:0] stuffed(input logic [DW-1:0] v);
`ifdef ZERO_STUFF_SAMPLE_HOLD_EN
    return v;
`else
    return '0;
`endif
  endfunction

  task automatic clr();
    in_v.delete(); in_l.delete(); ev.delete(); el.delete();
  endtask

  // One input symbol and the L output beats it should produce.
  task automatic add_sym(input int v, input int l, input bit last);
    in_v.push_back(DW'(v));
    in_l.push_back(last);
    ev.push_back(DW'(v));
    el.push_back(last && l == 1);
    for (int k = 1; k < l; k++) begin
      ev.push_back(stuffed(DW'(v)));
      el.push_back(last && k == l - 1);
    end
  endtask

  // mode 0: out_tready held high; mode 1: out_tready toggles 1,0,1,...
  // new_f >= 0: interp_factor is changed right after the first input handshake.
  task automatic run(input string tag, input int mode, input int new_f);
    int idx = 0;
    int c = 0;
    bit tog = 1'b1;
    bit stalled = 1'b0;
    bit chg = 1'b0;
    logic [DW-1:0] hd = '0;
    logic hl = 1'b0;
    ov.delete(); ol.delete(); oc.delete(); ic.delete();
    while (ov.size() < ev.size() && c < 400) begin
      @(negedge clock);
      if (chg) begin
        interp_factor = FW'(new_f);
        chg = 1'b0;
      end
      if (stalled) begin
        chk({tag, " stall data"}, 32'(data_out_tdata), 32'(hd));
        chk({tag, " stall tlast"}, 32'(data_out_tlast), 32'(hl));
      end
      data_in_tvalid  = (idx < in_v.size());
      data_in_tdata   = data_in_tvalid ? in_v[idx] : '0;
      data_in_tlast   = data_in_tvalid ? in_l[idx] : 1'b0;
      data_out_tready = (mode == 0) ? 1'b1 : tog;
      tog = !tog;
      #1;
      stalled = data_out_tvalid && !data_out_tready;
      if (stalled) begin
        hd = data_out_tdata;
        hl = data_out_tlast;
        chk({tag, " stall in_tready"}, 32'(data_in_tready), 32'd0);
      end
      if (data_in_tvalid && data_in_tready) begin
        ic.push_back(c);
        idx++;
        if (idx == 1 && new_f >= 0) chg = 1'b1;
      end
      if (data_out_tvalid && data_out_tready) begin
        ov.push_back(data_out_tdata);
        ol.push_back(data_out_tlast);
        oc.push_back(c);
      end
      c++;
    end
    chk({tag, " beat count"}, 32'(ov.size()), 32'(ev.size()));
    for (int i = 0; i < ov.size() && i < ev.size(); i++) begin
      chk($sformatf("%s beat%0d data", tag, i + 1), 32'(ov[i]), 32'(ev[i]));
      chk($sformatf("%s beat%0d tlast", tag, i + 1), 32'(ol[i]), 32'(el[i]));
    end
    @(negedge clock);
    data_in_tvalid  = 1'b0;
    data_in_tlast   = 1'b0;
    data_out_tready = 1'b1;
    #1;
    chk({tag, " idle tvalid"}, 32'(data_out_tvalid), 32'd0);
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    interp_factor   = FW'(1);
    data_in_tdata   = '0;
    data_in_tlast   = 1'b0;
    data_in_tvalid  = 1'b0;
    data_out_tready = 1'b0;
    #1;
    chk("reset tvalid", 32'(data_out_tvalid), 32'd0);
    chk("reset tlast", 32'(data_out_tlast), 32'd0);
    chk("reset tdata", 32'(data_out_tdata), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset in_tready", 32'(data_in_tready), 32'd1);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // L=4, three-symbol frame, tlast only on beat 12
    clr();
    interp_factor = FW'(4);
    add_sym(100, 4, 0); add_sym(-200, 4, 0); add_sym(300, 4, 1);
    run("L4", 0, -1);

    // L=1 pure pass-through, full rate, one-clock latency
    clr();
    interp_factor = FW'(1);
    for (int i = 1; i <= 8; i++) add_sym(i, 1, i == 8);
    run("L1", 0, -1);
    if (oc.size() == 8 && ic.size() == 8) begin
      chk("L1 latency", 32'(oc[0] - ic[0]), 32'd1);
      for (int i = 1; i < 8; i++) chk($sformatf("L1 no bubble %0d", i), 32'(oc[i] - oc[0]), 32'(i));
    end else begin
      chk("L1 handshake count", 32'(oc.size() + ic.size()), 32'd16);
    end

    // L=3 with downstream backpressure every other cycle
    clr();
    interp_factor = FW'(3);
    add_sym(5, 3, 0); add_sym(7, 3, 1);
    run("L3 stall", 1, -1);

    // Mid-frame factor change ignored; back-to-back next frame relatches 5 on the tlast cycle
    clr();
    interp_factor = FW'(2);
    add_sym(1, 2, 0); add_sym(2, 2, 1); add_sym(3, 5, 1);
    run("factor latch", 0, 5);

    // interp_factor=0 behaves as 1
    clr();
    interp_factor = FW'(0);
    add_sym(6, 1, 1);
    run("factor zero", 0, -1);

    // interp_factor=MAX_FACTOR+3 clamps to MAX_FACTOR
    clr();
    interp_factor = FW'(MF + 3);
    add_sym(8, MF, 1);
    run("factor clamp", 0, -1);

    // L=3 two-symbol frame (hold build repeats each sample)
    clr();
    interp_factor = FW'(3);
    add_sym(4, 3, 0); add_sym(-4, 3, 1);
    run("L3 pair", 0, -1);

    // Reset in the stuffed phase of an L=8 symbol
    interp_factor = FW'(8);
    @(negedge clock);
    data_in_tvalid  = 1'b1;
    data_in_tdata   = DW'(50);
    data_in_tlast   = 1'b1;
    data_out_tready = 1'b1;
    @(negedge clock);
    data_in_tvalid = 1'b0;
    data_in_tlast  = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("pre-reset tvalid", 32'(data_out_tvalid), 32'd1);
    chk("pre-reset busy", 32'(busy), 32'd1);
    chk("pre-reset tdata", 32'(data_out_tdata), 32'(stuffed(DW'(50))));
    #2;
    reset = 1'b1;
    #1;
    chk("async reset tvalid", 32'(data_out_tvalid), 32'd0);
    chk("async reset tlast", 32'(data_out_tlast), 32'd0);
    chk("async reset busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    clr();
    interp_factor = FW'(2);
    add_sym(9, 2, 1);
    run("post reset", 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
